// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// over WIDTH cycles, with architectural HI/LO registers and MTHI/MTLO writes.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [1:0]       state_o
);
   localparam int CW = $clog2(WIDTH);

   // Handshake: start_i is taken only in IDLE (busy_o=0); once taken, busy_o stays
   // high until the FIXUP edge, and done_o pulses for the one cycle after it.
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]      cnt;
   logic               is_div, neg_a, neg_b, dz_pend;
   logic [WIDTH-1:0]   opnd;   // multiplicand or divisor magnitude
   logic [WIDTH:0]     upper;  // product high half plus carry, or partial remainder
   logic [WIDTH-1:0]   lower;  // multiplier shifting out, or dividend/quotient shifting

   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     add_sum, shifted, diff;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign state_o = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = CALC;
         CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIXUP;
         FIXUP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mag1     = (op_i[0] && src1_i[WIDTH-1]) ? -src1_i : src1_i;
      mag2     = (op_i[0] && src2_i[WIDTH-1]) ? -src2_i : src2_i;
      add_sum  = upper + (lower[0] ? {1'b0, opnd} : '0);
      shifted  = {upper[WIDTH-1:0], lower[WIDTH-1]};
      diff     = shifted - {1'b0, opnd};
      prod     = {upper[WIDTH-1:0], lower};
      prod_fix = (neg_a ^ neg_b) ? -prod : prod;
      q_fix    = (neg_a ^ neg_b) ? -lower : lower;
      // With a zero divisor the remainder path ends holding |dividend|, so the
      // sign fix below reproduces the latched dividend for HI.
      r_fix    = neg_a ? -upper[WIDTH-1:0] : upper[WIDTH-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt        <= '0;
         is_div     <= 1'b0;
         neg_a      <= 1'b0;
         neg_b      <= 1'b0;
         dz_pend    <= 1'b0;
         opnd       <= '0;
         upper      <= '0;
         lower      <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         div_zero_o <= 1'b0;
         hi_o       <= '0;
         lo_o       <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_we_i) hi_o <= wdata_i;
               if (lo_we_i) lo_o <= wdata_i;
               if (start_i) begin
                  busy_o     <= 1'b1;
                  div_zero_o <= 1'b0;
                  cnt        <= '0;
                  is_div     <= op_i[1];
                  neg_a      <= op_i[0] & src1_i[WIDTH-1];
                  neg_b      <= op_i[0] & src2_i[WIDTH-1];
                  dz_pend    <= op_i[1] && (src2_i == '0);
                  opnd       <= op_i[1] ? mag2 : mag1;
                  lower      <= op_i[1] ? mag1 : mag2;
                  upper      <= '0;
               end
            end
            CALC: begin
               cnt <= cnt + CW'(1);
               if (is_div) begin
                  if (!diff[WIDTH]) begin
                     upper <= diff;
                     lower <= {lower[WIDTH-2:0], 1'b1};
                  end else begin
                     upper <= shifted;
                     lower <= {lower[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  upper <= {1'b0, add_sum[WIDTH:1]};
                  lower <= {add_sum[0], lower[WIDTH-1:1]};
               end
            end
            FIXUP: begin
               busy_o <= 1'b0;
               done_o <= 1'b1;
               if (is_div) begin
                  hi_o       <= r_fix;
                  lo_o       <= dz_pend ? '1 : q_fix;
                  div_zero_o <= dz_pend;
               end else begin
                  {hi_o, lo_o} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: fixed vector table, randomized ops against an arithmetic
// reference model, and hand sequences for protocol and reset corners.
module tb_mdu_iter;
   logic        clk = 1'b0;
   logic        rst, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] src1, src2, wdata;
   logic        busy, done, dz;
   logic [31:0] hi, lo;
   logic [1:0]  st;

   int vecs = 0;
   int miscmp = 0;

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
      .src1_i(src1), .src2_i(src2), .hi_we_i(hi_we), .lo_we_i(lo_we),
      .wdata_i(wdata), .busy_o(busy), .done_o(done), .div_zero_o(dz),
      .hi_o(hi), .lo_o(lo), .state_o(st)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dz;
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values.
   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] mhi, output logic [31:0] mlo,
                                 output logic mdz);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      mdz = 1'b0;
      mhi = '0;
      mlo = '0;
      case (o)
         2'b00: begin p = 64'(a) * 64'(b); {mhi, mlo} = p; end
         2'b01: begin p = 64'(sa * sb);   {mhi, mlo} = p; end
         default: begin
            if (b == 32'h0) begin
               mdz = 1'b1; mlo = 32'hffff_ffff; mhi = a;
            end else if (o == 2'b10) begin
               mlo = a / b; mhi = a % b;
            end else begin
               q = sa / sb; r = sa % sb;
               mlo = 32'(q); mhi = 32'(r);
            end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hffff_ffff;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge with the unit idle (or showing done); returns at the
   // negedge where done is seen, so successive calls issue back-to-back.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input bit hold_start, input bit mthi_at_start,
                        input int mtlo_k);
      int lat, busy_cnt;
      logic [31:0] hi1, lo1;
      lat = 0; busy_cnt = 0; hi1 = '0; lo1 = '0;
      start = 1'b1; op = o; src1 = a; src2 = b;
      if (mthi_at_start) begin hi_we = 1'b1; wdata = 32'h0000_c0de; end
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      hi_we = 1'b0;
      src1 = $urandom; src2 = $urandom; op = 2'($urandom_range(0, 3));
      for (int k = 1; k <= 40; k++) begin
         if (k == 1) begin
            check({tag, " dz_clear"}, 32'(dz), 32'h0);
            hi1 = hi; lo1 = lo;
            if (mthi_at_start) check({tag, " mthi_with_start"}, hi, 32'h0000_c0de);
         end
         if (k == mtlo_k) begin lo_we = 1'b1; wdata = 32'h0000_aaaa; end
         if (k == mtlo_k + 1) lo_we = 1'b0;
         if (k == 33) begin
            check({tag, " hi_hold"}, hi, hi1);
            check({tag, " lo_hold"}, lo, lo1);
         end
         if (busy) busy_cnt++;
         if (done) begin lat = k; break; end
         @(negedge clk);
      end
      start = 1'b0; lo_we = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'd34);
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
      check({tag, " hi"}, hi, ehi);
      check({tag, " lo"}, lo, elo);
      check({tag, " div_zero"}, 32'(dz), 32'(edz));
   endtask

   initial begin
      logic [31:0] mhi, mlo;
      logic        mdz;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          dones;

      tbl[0] = '{2'b00, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001, 1'b0};
      tbl[1] = '{2'b01, 32'hffff_fffd, 32'h0000_0007, 32'hffff_ffff, 32'hffff_ffeb, 1'b0};
      tbl[2] = '{2'b11, 32'hffff_fff9, 32'h0000_0002, 32'hffff_ffff, 32'hffff_fffd, 1'b0};
      tbl[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      tbl[4] = '{2'b10, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hffff_ffff, 1'b1};
      tbl[5] = '{2'b11, 32'h8000_0000, 32'hffff_ffff, 32'h0,         32'h8000_0000, 1'b0};
      tbl[6] = '{2'b11, 32'hffff_fff9, 32'h0,         32'hffff_fff9, 32'hffff_ffff, 1'b1};
      tbl[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
      tbl[8] = '{2'b11, 32'h0000_0007, 32'hffff_fffe, 32'h0000_0001, 32'hffff_fffd, 1'b0};

      rst = 1'b1; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst busy", 32'(busy), 32'h0);
      check("rst done", 32'(done), 32'h0);
      check("rst div_zero", 32'(dz), 32'h0);
      check("rst hi", hi, 32'h0);
      check("rst lo", lo, 32'h0);
      check("rst state", 32'(st), 32'h0);

      hi_we = 1'b1; wdata = 32'h55;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi hi", hi, 32'h55);
      check("mthi lo_untouched", lo, 32'h0);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      check("mthi_mtlo hi", hi, 32'h1111);
      check("mthi_mtlo lo", lo, 32'h1111);

      for (int i = 0; i < 9; i++)
         do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].hi, tbl[i].lo, tbl[i].dz, 1'b0, (i == 1), (i == 3) ? 10 : 0);

      for (int i = 0; i < 25; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         model(ro, ra, rb, mhi, mlo, mdz);
         do_op($sformatf("rnd%0d op%0d %h,%h", i, ro, ra, rb), ro, ra, rb, mhi, mlo, mdz,
               1'b0, 1'b0, 0);
      end

      ra = $urandom; rb = $urandom;
      model(2'b00, ra, rb, mhi, mlo, mdz);
      do_op("hold_start", 2'b00, ra, rb, mhi, mlo, mdz, 1'b1, 1'b0, 0);
      @(negedge clk);
      check("hold_start single_op busy", 32'(busy), 32'h0);
      check("hold_start single_op done", 32'(done), 32'h0);

      start = 1'b1; op = 2'b01; src1 = 32'hffff_fffb; src2 = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst busy", 32'(busy), 32'h0);
      check("midrst done", 32'(done), 32'h0);
      check("midrst hi", hi, 32'h0);
      check("midrst lo", lo, 32'h0);
      check("midrst state", 32'(st), 32'h0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("midrst no_done", 32'(dones), 32'h0);

      model(2'b01, 32'hffff_fffd, 32'd7, mhi, mlo, mdz);
      do_op("after_rst", 2'b01, 32'hffff_fffd, 32'd7, mhi, mlo, mdz, 1'b0, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end
endmodule
